// File: rtl/projectile_pool.sv
// Pool of NUM_PROJ projectiles: fire arbitration with cooldown, screen-edge retirement, per-pixel hit.
// Optional build macro PROJ_KILL_EN adds a per-slot kill input driven by collision logic.
module projectile_pool #(
  parameter int NUM_PROJ = 4,
  parameter int SIZE     = 20,
  parameter int SPEED    = 2,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COOLDOWN = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                fire,
  input  logic [1:0]          dir,
  input  logic [9:0]          origin_x,
  input  logic [9:0]          origin_y,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
`ifdef PROJ_KILL_EN
  input  logic [NUM_PROJ-1:0] kill,
`endif
  output logic [NUM_PROJ-1:0] active,
  output logic                launched,
  output logic                proj_on,
  output logic [2:0]          proj_idx,
  output logic [9:0]          proj_dx,
  output logic [9:0]          proj_dy
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_UP = 2'd3} dir_e;

  logic [9:0]          pos_x   [NUM_PROJ];
  logic [9:0]          pos_y   [NUM_PROJ];
  dir_e                pos_dir [NUM_PROJ];
  logic [CD_W-1:0]     cooldown;
  logic                fire_pend;
  logic                fc_q1, fc_q2;
  logic                tick;

  logic [NUM_PROJ-1:0] nxt_active;
  logic [9:0]          nxt_x   [NUM_PROJ];
  logic [9:0]          nxt_y   [NUM_PROJ];
  logic [10:0]         fwd_x   [NUM_PROJ];
  logic [10:0]         fwd_y   [NUM_PROJ];
  logic [9:0]          hit_dx  [NUM_PROJ];
  logic [9:0]          hit_dy  [NUM_PROJ];
  logic                do_launch;
  logic [2:0]          launch_slot;

  // frame_clk is asynchronous; the two-stage register also gives a clean rising-edge detect.
  assign tick = fc_q1 & ~fc_q2;

  // Movement/retirement outcome for the coming tick, then lowest free slot after retirement.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nxt_active  = active;
    do_launch   = 1'b0;
    launch_slot = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      nxt_x[i] = pos_x[i];
      nxt_y[i] = pos_y[i];
      fwd_x[i] = {1'b0, pos_x[i]} + 11'(SPEED);
      fwd_y[i] = {1'b0, pos_y[i]} + 11'(SPEED);
      if (active[i]) begin
        unique case (pos_dir[i])
          DIR_RIGHT: if (fwd_x[i] > 11'(SCREEN_W - SIZE)) nxt_active[i] = 1'b0;
                     else nxt_x[i] = fwd_x[i][9:0];
          DIR_LEFT:  if (pos_x[i] < 10'(SPEED)) nxt_active[i] = 1'b0;
                     else nxt_x[i] = pos_x[i] - 10'(SPEED);
          DIR_DOWN:  if (fwd_y[i] > 11'(SCREEN_H - SIZE)) nxt_active[i] = 1'b0;
                     else nxt_y[i] = fwd_y[i][9:0];
          DIR_UP:    if (pos_y[i] < 10'(SPEED)) nxt_active[i] = 1'b0;
                     else nxt_y[i] = pos_y[i] - 10'(SPEED);
        endcase
      end
    end
    if (fire_pend && cooldown == '0) begin
      for (int i = NUM_PROJ - 1; i >= 0; i--) begin
        if (!nxt_active[i]) begin
          do_launch   = 1'b1;
          launch_slot = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the slot arrays are a handful of flops, not a RAM, so clearing them on reset is cheap and intended.
      fc_q1     <= 1'b0;
      fc_q2     <= 1'b0;
      fire_pend <= 1'b0;
      cooldown  <= '0;
      launched  <= 1'b0;
      active    <= '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        pos_x[i]   <= '0;
        pos_y[i]   <= '0;
        pos_dir[i] <= DIR_RIGHT;
      end
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      fc_q1     <= frame_clk;
      fc_q2     <= fc_q1;
      launched  <= tick && do_launch;
      fire_pend <= (tick && do_launch) ? fire : (fire_pend | fire);
      if (tick) begin
        active <= nxt_active;
        for (int i = 0; i < NUM_PROJ; i++) begin
          pos_x[i] <= nxt_x[i];
          pos_y[i] <= nxt_y[i];
        end
        if (do_launch)           cooldown <= CD_W'(COOLDOWN);
        else if (cooldown != '0) cooldown <= cooldown - 1'b1;
      end
`ifdef PROJ_KILL_EN
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (kill[i]) active[i] <= 1'b0;
      end
`endif
      // Later assignment lets a launch override a coincident kill of the same slot.
      if (tick && do_launch) begin
        for (int i = 0; i < NUM_PROJ; i++) begin
          if (launch_slot == 3'(i)) begin
            active[i]  <= 1'b1;
            pos_x[i]   <= origin_x;
            pos_y[i]   <= origin_y;
            pos_dir[i] <= dir_e'(dir);
          end
        end
      end
    end
  end

  // Pixel hit: unsigned wrap makes pixels left/above the sprite fail the < SIZE test.
  always_comb begin
    proj_on  = 1'b0;
    proj_idx = '0;
    proj_dx  = '0;
    proj_dy  = '0;
    for (int i = NUM_PROJ - 1; i >= 0; i--) begin
      hit_dx[i] = DrawX - pos_x[i];
      hit_dy[i] = DrawY - pos_y[i];
      if (active[i] && hit_dx[i] < 10'(SIZE) && hit_dy[i] < 10'(SIZE)) begin
        proj_on  = 1'b1;
        proj_idx = 3'(i);
        proj_dx  = hit_dx[i];
        proj_dy  = hit_dy[i];
      end
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Randomized self-checking bench for projectile_pool against a frame-level behavioural model.
module tb_projectile_pool;

  localparam int N  = 4;
  localparam int SZ = 20;
  localparam int SP = 2;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int CD = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         frame_clk = 1'b0;
  logic         fire = 1'b0;
  logic [1:0]   dir = '0;
  logic [9:0]   origin_x = '0;
  logic [9:0]   origin_y = '0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
`ifdef PROJ_KILL_EN
  logic [N-1:0] kill = '0;
`endif
  logic [N-1:0] active;
  logic         launched;
  logic         proj_on;
  logic [2:0]   proj_idx;
  logic [9:0]   proj_dx;
  logic [9:0]   proj_dy;

  projectile_pool #(
    .NUM_PROJ(N), .SIZE(SZ), .SPEED(SP), .SCREEN_W(SW), .SCREEN_H(SH), .COOLDOWN(CD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire), .dir(dir),
    .origin_x(origin_x), .origin_y(origin_y), .DrawX(DrawX), .DrawY(DrawY),
`ifdef PROJ_KILL_EN
    .kill(kill),
`endif
    .active(active), .launched(launched), .proj_on(proj_on), .proj_idx(proj_idx),
    .proj_dx(proj_dx), .proj_dy(proj_dy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int launch_seen = 0;

  always @(negedge Clk) if (launched === 1'b1) launch_seen++;

  // Reference model: slot table, cooldown counter and pending request, advanced once per frame.
  int mx [N];
  int my [N];
  int md [N];
  bit mact [N];
  int mcd;
  bit mpend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_active();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mact[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; md[i] = 0; mact[i] = 1'b0;
    end
    mcd = 0;
    mpend = 1'b0;
  endfunction

  // One tick with fire held at level f for the whole frame.
  function automatic bit model_tick(input bit f, input int d, input int ox, input int oy);
    int  cd_before;
    bit  lau;
    mpend = mpend | f;
    for (int i = 0; i < N; i++) begin
      if (mact[i]) begin
        case (md[i])
          0: if (mx[i] + SP > SW - SZ) mact[i] = 1'b0; else mx[i] = mx[i] + SP;
          1: if (mx[i] < SP)           mact[i] = 1'b0; else mx[i] = mx[i] - SP;
          2: if (my[i] + SP > SH - SZ) mact[i] = 1'b0; else my[i] = my[i] + SP;
          default: if (my[i] < SP)     mact[i] = 1'b0; else my[i] = my[i] - SP;
        endcase
      end
    end
    cd_before = mcd;
    if (mcd != 0) mcd = mcd - 1;
    lau = 1'b0;
    if (mpend && cd_before == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!lau && !mact[i]) begin
          mact[i] = 1'b1; mx[i] = ox; my[i] = oy; md[i] = d;
          mcd = CD; mpend = 1'b0; lau = 1'b1;
        end
      end
    end
    mpend = mpend | f;
    return lau;
  endfunction

  task automatic do_reset();
    fire = 1'b0;
    frame_clk = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_clear();
  endtask

  task automatic run_frame(input bit f, input int d, input int ox, input int oy, output int nl);
    bit lau;
    fire = f; dir = 2'(d); origin_x = 10'(ox); origin_y = 10'(oy);
    @(negedge Clk);
    launch_seen = 0;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    lau = model_tick(f, d, ox, oy);
    nl = launch_seen;
    check("launched", 32'(nl), 32'(lau));
    check("active", 32'(active), 32'(model_active()));
  endtask

  task automatic pix_check(input int px, input int py);
    bit eon;
    int eidx, edx, edy;
    DrawX = 10'(px); DrawY = 10'(py);
    #1;
    eon = 1'b0; eidx = 0; edx = 0; edy = 0;
    for (int i = 0; i < N; i++) begin
      if (!eon && mact[i] && ((px - mx[i]) & 1023) < SZ && ((py - my[i]) & 1023) < SZ) begin
        eon = 1'b1; eidx = i; edx = (px - mx[i]) & 1023; edy = (py - my[i]) & 1023;
      end
    end
    check("proj_on", 32'(proj_on), 32'(eon));
    if (eon) begin
      check("proj_idx", 32'(proj_idx), 32'(eidx));
      check("proj_dx", 32'(proj_dx), 32'(edx));
      check("proj_dy", 32'(proj_dy), 32'(edy));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl;
    int total;
    model_clear();
    do_reset();
    check("reset_active", 32'(active), 32'(0));
    check("reset_launched", 32'(launched), 32'(0));
    pix_check(0, 0);

    // Single shot to the right, three moves, edge-of-sprite pixels.
    run_frame(1'b1, 0, 10, 192, nl);
    check("first_launch", 32'(nl), 32'(1));
    check("first_active", 32'(active), 32'(4'b0001));
    repeat (3) run_frame(1'b0, 0, 0, 0, nl);
    DrawX = 10'd16; DrawY = 10'd192; #1;
    check("hit_on", 32'(proj_on), 32'(1));
    check("hit_idx", 32'(proj_idx), 32'(0));
    check("hit_dx", 32'(proj_dx), 32'(0));
    DrawX = 10'd36; #1;
    check("edge_off", 32'(proj_on), 32'(0));
    pix_check(35, 211);

    // Held fire: one launch per cooldown window until the pool fills.
    do_reset();
    total = 0;
    for (int k = 1; k <= 40; k++) begin
      run_frame(1'b1, 0, 10, 20 * k, nl);
      total += nl;
    end
    check("hold_full", 32'(active), 32'(4'b1111));
    check("hold_count", 32'(total), 32'(4));

    // Leftward from x=3: survives one tick (x=1), retires on the next.
    do_reset();
    run_frame(1'b1, 1, 3, 50, nl);
    run_frame(1'b0, 0, 0, 0, nl);
    check("left_alive", 32'(active[0]), 32'(1));
    pix_check(1, 50);
    run_frame(1'b0, 0, 0, 0, nl);
    check("left_retired", 32'(active[0]), 32'(0));

    // Full pool; slot 2 retires at the right edge on the tick cooldown has expired.
    do_reset();
    for (int k = 1; k <= 37; k++) begin
      if (k == 19)      run_frame(1'b1, 0, 586, 100, nl);
      else if (k == 37) run_frame(1'b1, 0, 300, 300, nl);
      else              run_frame(1'b1, 2, 50, 0, nl);
    end
    check("reuse_launch", 32'(nl), 32'(1));
    check("reuse_full", 32'(active), 32'(4'b1111));
    DrawX = 10'd300; DrawY = 10'd300; #1;
    check("reuse_idx", 32'(proj_idx), 32'(2));

    // Slots 1 and 3 stacked on the same spot: lowest index wins.
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      if (k == 1)       run_frame(1'b1, 2, 50, 0, nl);
      else if (k == 10) run_frame(1'b1, 2, 200, 0, nl);
      else if (k == 19) run_frame(1'b1, 2, 400, 0, nl);
      else if (k == 28) run_frame(1'b1, 2, 200, 36, nl);
      else              run_frame(1'b1, 2, 0, 0, nl);
    end
    fire = 1'b0;
    DrawX = 10'd205; DrawY = 10'd40; #1;
    check("overlap_on", 32'(proj_on), 32'(1));
    check("overlap_idx", 32'(proj_idx), 32'(1));
    check("overlap_dx", 32'(proj_dx), 32'(5));
    check("overlap_dy", 32'(proj_dy), 32'(4));

`ifdef PROJ_KILL_EN
    @(negedge Clk);
    kill = 4'b0100;
    @(negedge Clk);
    kill = '0;
    mact[2] = 1'b0;
    check("kill_slot2", 32'(active[2]), 32'(0));
    check("kill_active", 32'(active), 32'(model_active()));
`endif

    // Reset while slots are in flight, then an immediate launch (cooldown cleared).
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset_active", 32'(active), 32'(0));
    Reset = 1'b0;
    model_clear();
    run_frame(1'b1, 0, 100, 100, nl);
    check("post_reset_launch", 32'(nl), 32'(1));

    // Randomized traffic with pixel probes inside every live sprite plus one anywhere.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, SW - SZ)), int'($urandom_range(0, SH - SZ)), nl);
      for (int i = 0; i < N; i++) begin
        if (mact[i]) pix_check(mx[i] + int'($urandom_range(0, SZ - 1)), my[i] + int'($urandom_range(0, SZ - 1)));
      end
      pix_check(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
